// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// Sequencing controller for the SPI master path, SPI mode 0 (CPOL=0, CPHA=0).
// Accepts a one-word transfer request and drives cs_n/sclk/mosi. It also
// generates the sampl_en strobe used by the external MISO shift register, and
// captures the received word internally.
//
// Parameters:
//   DATA_WIDTH : bits per transfer (>= 2)
//   CLK_DIV    : clk cycles per sclk half-period (>= 1)
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   start      : transfer request, sampled only while idle
//   tx_data    : word to transmit, latched when start is accepted
//   busy       : high from the cycle after acceptance until done
//   done       : one-cycle completion pulse
//   rx_data    : received word, updated with done, otherwise held
//   sampl_en   : one-cycle strobe coinciding with each sclk rising edge
//   cs_n, sclk, mosi : SPI pins (outputs)
//   miso       : SPI data in, already synchronised
//
// Build option:
//   SPI_LSB_FIRST_EN : when defined, both mosi and the rx capture are LSB
//                      first. When undefined, both are MSB first.
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sampl_en,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sampl_en_q, sampl_en_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sclk_q, sclk_d;

    logic                    half_end;
    logic [CNT_W-1:0]        cnt_inc;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;

    // Half-period timing: the counter wraps at CLK_DIV-1 in every non-idle state
    assign half_end = (cnt_q == CNT_LAST);
    assign cnt_inc  = half_end ? '0 : cnt_q + CNT_W'(1);

    // Bit-order dependent shifters; mosi is always the outgoing end of tx_q
`ifdef SPI_LSB_FIRST_EN
    assign tx_shift = {1'b0, tx_q[DATA_WIDTH-1:1]};
    assign rx_shift = {miso, rx_q[DATA_WIDTH-1:1]};
    assign mosi     = tx_q[0];
`else
    assign tx_shift = {tx_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shift = {rx_q[DATA_WIDTH-2:0], miso};
    assign mosi     = tx_q[DATA_WIDTH-1];
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sampl_en_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sampl_en_q <= sampl_en_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sampl_en_d = 1'b0;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    tx_d    = tx_data;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                cnt_d = cnt_inc;
                if (half_end) begin
                    state_d = ST_XFER;
                end
            end

            // sclk toggles at the end of each half-period; the final fall enters HOLD
            ST_XFER: begin
                cnt_d = cnt_inc;
                if (half_end) begin
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        sampl_en_d = 1'b1;
                        rx_d       = rx_shift;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                            tx_d  = tx_shift;
                        end
                    end
                end
            end

            ST_HOLD: begin
                cnt_d = cnt_inc;
                if (half_end) begin
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign sampl_en = sampl_en_q;
    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl. The main instance uses DATA_WIDTH=8 and
// CLK_DIV=2. A second instance with CLK_DIV=1 exercises the fastest sclk.
// A simple SPI slave model drives miso and collects mosi on each sampl_en.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, sampl_en, cs_n, sclk, mosi, miso;
    logic [7:0] rx_data;

    logic       f_start;
    logic [7:0] f_tx_data;
    logic       f_busy, f_done, f_sampl_en, f_cs_n, f_sclk, f_mosi, f_miso;
    logic [7:0] f_rx_data;

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sampl_en (sampl_en),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .start    (f_start),
        .tx_data  (f_tx_data),
        .busy     (f_busy),
        .done     (f_done),
        .rx_data  (f_rx_data),
        .sampl_en (f_sampl_en),
        .cs_n     (f_cs_n),
        .sclk     (f_sclk),
        .mosi     (f_mosi),
        .miso     (f_miso)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_rx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmission-order index -> word bit position
    function automatic int bit_pos(input int idx);
`ifdef SPI_LSB_FIRST_EN
        return idx;
`else
        return 7 - idx;
`endif
    endfunction

    function automatic logic slave_bit(input logic [7:0] w, input int idx);
        logic [7:0] t;
        t = w;
        if (idx >= 8) return 1'b0;
        return t[bit_pos(idx)];
    endfunction

    // One transfer on the CLK_DIV=2 instance; returns with the bench sitting in the done cycle.
    task automatic run_frame(input logic [7:0] tx, input logic [7:0] sw, input bit keep,
                             input logic [7:0] nxt_tx, input int ign_at);
        int         n_se, n_cs_lo, se_bad, rx_held_bad, done_cyc;
        logic [7:0] mosi_w;
        n_se = 0; n_cs_lo = 0; se_bad = 0; rx_held_bad = 0; done_cyc = -1;
        mosi_w = 8'h00;
        start   = 1'b1;
        tx_data = tx;
        miso    = slave_bit(sw, 0);
        @(posedge clk); #1;
        start   = keep;
        tx_data = nxt_tx;
        for (int cyc = 1; cyc <= 45 && done_cyc < 0; cyc++) begin
            if (cyc == 1) begin
                check_eq("first_mosi", 32'(mosi), 32'(slave_bit(tx, 0)));
                check_eq("busy_rise", 32'(busy), 32'd1);
                check_eq("cs_fall", 32'(cs_n), 32'd0);
                check_eq("sclk_low_setup", 32'(sclk), 32'd0);
            end
            if (!cs_n) n_cs_lo++;
            if (sampl_en) begin
                if (cyc < 3 || cyc > 34 || !sclk) se_bad++;
                if (n_se < 8) mosi_w[bit_pos(n_se)] = mosi;
                n_se++;
                miso = slave_bit(sw, n_se);
            end
            if (done) begin
                done_cyc = cyc;
                check_eq("rx_data", 32'(rx_data), 32'(sw));
                check_eq("cs_high_at_done", 32'(cs_n), 32'd1);
                check_eq("busy_low_at_done", 32'(busy), 32'd0);
            end else if (rx_data !== last_rx) begin
                rx_held_bad++;
            end
            if (ign_at >= 0 && cyc == ign_at)     start = 1'b1;
            if (ign_at >= 0 && cyc == ign_at + 3) start = 1'b0;
            if (done_cyc < 0) begin
                @(posedge clk); #1;
            end
        end
        check_eq("done_cycle", 32'(done_cyc), 32'd37);
        check_eq("sampl_en_count", 32'(n_se), 32'd8);
        check_eq("cs_low_cycles", 32'(n_cs_lo), 32'd36);
        check_eq("sampl_en_placement", 32'(se_bad), 32'd0);
        check_eq("mosi_word", 32'(mosi_w), 32'(tx));
        check_eq("rx_held", 32'(rx_held_bad), 32'd0);
        last_rx = sw;
    endtask

    task automatic idle_check(input int n);
        int extra, cs_lo;
        extra = 0; cs_lo = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) extra++;
            if (!cs_n) cs_lo++;
        end
        check_eq("no_extra_done", 32'(extra), 32'd0);
        check_eq("cs_idle_high", 32'(cs_lo), 32'd0);
    endtask

    // One transfer on the CLK_DIV=1 instance: sclk period 2, latency 19.
    task automatic run_fast(input logic [7:0] tx, input logic [7:0] sw);
        int         n_se, toggles, se_bad, done_cyc;
        logic       prev_sclk;
        logic [7:0] mosi_w;
        n_se = 0; toggles = 0; se_bad = 0; done_cyc = -1;
        prev_sclk = 1'b0;
        mosi_w = 8'h00;
        f_start   = 1'b1;
        f_tx_data = tx;
        f_miso    = slave_bit(sw, 0);
        @(posedge clk); #1;
        f_start = 1'b0;
        for (int cyc = 1; cyc <= 25 && done_cyc < 0; cyc++) begin
            if (f_sclk !== prev_sclk) toggles++;
            if (f_sampl_en !== (!prev_sclk && f_sclk)) se_bad++;
            if (f_sampl_en && (cyc < 2 || cyc > 17)) se_bad++;
            prev_sclk = f_sclk;
            if (f_sampl_en) begin
                if (n_se < 8) mosi_w[bit_pos(n_se)] = f_mosi;
                n_se++;
                f_miso = slave_bit(sw, n_se);
            end
            if (f_done) begin
                done_cyc = cyc;
                check_eq("fast_rx_data", 32'(f_rx_data), 32'(sw));
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq("fast_done_cycle", 32'(done_cyc), 32'd19);
        check_eq("fast_sclk_toggles", 32'(toggles), 32'd16);
        check_eq("fast_sampl_en_align", 32'(se_bad), 32'd0);
        check_eq("fast_sampl_en_count", 32'(n_se), 32'd8);
        check_eq("fast_mosi_word", 32'(mosi_w), 32'(tx));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_data = 8'h00; miso = 1'b0;
        f_start = 1'b0; f_tx_data = 8'h00; f_miso = 1'b0;
        last_rx = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 32'(cs_n), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sampl_en", 32'(sampl_en), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic transfer: A5 out, 3C back
        run_frame(8'hA5, 8'h3C, 1'b0, 8'h00, -1);
        idle_check(4);

        // Fastest sclk
        run_fast(8'h6B, 8'hD2);

        // start with a different word mid-transfer is ignored
        run_frame(8'h81, 8'h5E, 1'b0, 8'hFF, 10);
        idle_check(6);

        // Back-to-back with start held high
        run_frame(8'h12, 8'hC7, 1'b1, 8'h34, -1);
        run_frame(8'h34, 8'h29, 1'b0, 8'h00, -1);
        idle_check(4);

        // Reset in cycle 10 of a transfer
        start = 1'b1; tx_data = 8'hC3; miso = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check_eq("mid_rst_sclk", 32'(sclk), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_sampl_en", 32'(sampl_en), 32'd0);
        check_eq("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        last_rx = 8'h00;
        idle_check(40);
        run_frame(8'h5A, 8'h96, 1'b0, 8'h00, -1);
        idle_check(3);

`ifdef SPI_LSB_FIRST_EN
        // LSB first: 0x01 out, miso 1 then zeros -> rx 0x01
        run_frame(8'h01, 8'h01, 1'b0, 8'h00, -1);
        idle_check(3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
